fpu_addsub_seq: RTL and testbench
=================================

// Module: fpu_addsub_seq
// PURPOSE
// - Multi-cycle floating-point add/subtract unit for the pipeline's FPU path (ADDS).
// - Parametrised in exponent and mantissa width; FP32 by default.
// - Started by the X stage via start/op; busy feeds the hazard unit's fpu_working.
// - Result is written back through the FPU write port when done pulses.
// PARAMETERS
// - EXP_W  default 8   exponent field width
// - MNT_W  default 23  stored mantissa field width; word width W = 1+EXP_W+MNT_W
// PORTS
// - clk       in   1  single clock, rising edge
// - rst_n     in   1  synchronous, active-low reset
// - start     in   1  request; sampled only in IDLE or DONE
// - op        in   1  0 = a+b, 1 = a-b
// - a         in   W  operand {sign,exp,mnt}
// - b         in   W  operand {sign,exp,mnt}
// - busy      out  1  high in every state except IDLE
// - done      out  1  one-cycle pulse; result valid
// - result    out  W  sum/difference; held until the next accepted start
// - overflow  out  1  result saturated to infinity; valid with done, held
// - zero      out  1  result is +0/-0; valid with done, held
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state=IDLE; busy, done, overflow, zero = 0; result = 0.
// - Reset mid-operation aborts; the partial result is discarded.
// - States: IDLE -> CMP -> ALIGN -> OP -> NORM -> [RND] -> DONE.
// - DONE returns to IDLE, or to CMP if start=1 (back-to-back issue).
// - start in CMP..RND is ignored; operands are not re-sampled.
// - Accept: when start=1 in IDLE/DONE, a and b are registered, with b.sign ^= op.
// - Timing: start in cycle 0 -> done in cycle 5. With the rounding option, done is in cycle 6.
// - CMP: larger magnitude -> gt, other -> lt. Magnitude compares exp, then mnt.
//   - Ties: gt = a.
//   - Result sign = gt.sign; eff_sub = gt.sign ^ lt.sign.
//   - Exponent 0 flushes that operand to zero (no denormals).
// - ALIGN: mantissas extended as {hidden 1, mnt, G,R,S}, MNT_W+4 bits.
//   - lt is shifted right by e_dif = gt.exp - lt.exp; shifted-out bits OR into S.
//   - If e_dif >= MNT_W+4, lt becomes 0 with S = 1 if lt was nonzero.
// - OP: MNT_W+5-bit sum or difference (gt - lt, never negative).
// - NORM:
//   - Carry out: shift right 1, exp+1, keep sticky.
//   - Otherwise shift left to the leading one, found with a single-cycle priority encoder; exp -= shift.
//   - Exact zero -> result = +0, zero = 1.
//   - exp <= 0 after the left shift -> signed zero, zero = 1 (flush underflow).
// - Overflow: final exp >= 2^EXP_W-1 -> {sign, all-ones, 0}, overflow = 1.
// - Inputs with exp all ones (inf/NaN) are treated as ordinary numbers; not IEEE-compliant.
// CONFIGURATION
// - Macro: FPU_ROUND_NEAREST_EN.
// - Defined:
//   - Extra RND state performs round-to-nearest-even on G,R,S.
//   - Round up when G & (R | S | lsb).
//   - A mantissa carry from rounding renormalises (exp+1) and may raise overflow.
//   - Latency is 6.
// - Undefined:
//   - Truncation: G,R,S are dropped and there is no RND state.
//   - Latency is 5.
// TESTING
// - 0x3F800000 + 0x3F800000, op=0 -> result 0x40000000 at cycle 5 (6 with RND); zero=0, overflow=0.
// - 0x40400000 - 0x3F800000, op=1 -> 0x40000000.
// - 0x3F800000 - 0x3F800000 -> 0x00000000, zero=1.
// - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1.
// - 0x3F800000 + 0x33C00000 -> 0x3F800001 with FPU_ROUND_NEAREST_EN; 0x3F800000 without it.
// - Mid-operation events:
//   - Second start in cycle 2 is ignored; the result is that of the first operands.
//   - rst_n=0 in cycle 3: busy=0, result=0 next cycle, and done never pulses.

Source files
------------

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle floating-point add/subtract, FP32 by default, no denormals.
// Define FPU_ROUND_NEAREST_EN for a round-to-nearest-even stage (latency 6 instead of 5).
module fpu_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MNT_W = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   op_i,
    input  logic [EXP_W+MNT_W:0]   a_i,
    input  logic [EXP_W+MNT_W:0]   b_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [EXP_W+MNT_W:0]   result_o,
    output logic                   overflow_o,
    output logic                   zero_o
);
    localparam int W   = 1 + EXP_W + MNT_W;
    localparam int M   = MNT_W + 4;
    localparam int XW  = EXP_W + 2;
    localparam int LZW = $clog2(M + 1);

    typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, RND, DONE} state_e;

    state_e           state_q;
    logic [W-1:0]     a_q, b_q, result_q;
    logic             busy_q, done_q, ovf_q, zero_q, sign_q, sub_q;
    logic [EXP_W-1:0] exp_q, edif_q;
    logic [M-1:0]     gm_q, lm_q;
    logic [M:0]       sum_q;

    function automatic logic [W-1:0] flush(input logic [W-1:0] x);
        return {x[W-1], x[W-2:MNT_W], x[MNT_W-1:0] & {MNT_W{|x[W-2:MNT_W]}}};
    endfunction

    function automatic logic [M-1:0] ext(input logic [W-1:0] x);
        return {|x[W-2:MNT_W], x[MNT_W-1:0], 3'b000};
    endfunction

    logic         a_ge, far;
    logic [W-1:0] gt, lt;
    logic [M-1:0] lsh;
    assign a_ge = a_q[W-2:0] >= b_q[W-2:0];
    assign gt   = a_ge ? a_q : b_q;
    assign lt   = a_ge ? b_q : a_q;
    assign far  = 32'(edif_q) >= M;
    assign lsh  = lm_q >> edif_q;

    logic [LZW-1:0] lz;
    logic [M-1:0]   nmant;
    logic [XW-1:0]  nexp;
    logic           nzero, nplus;
    always_comb begin
        lz = '0;
        for (int i = 0; i < M; i++) if (sum_q[i]) lz = LZW'(M - 1 - i);
        nmant = sum_q[M] ? {sum_q[M:2], |sum_q[1:0]} : sum_q[M-1:0] << lz;
        nexp  = sum_q[M] ? XW'(exp_q) + XW'(1) : XW'(exp_q) - XW'(lz);
        nplus = ~|sum_q;
        nzero = nplus | nexp[XW-1] | ~|nexp;
    end

    logic [XW-1:0]    fexp;
    logic [MNT_W-1:0] ffrac;
    logic             fzero, fplus;
`ifdef FPU_ROUND_NEAREST_EN
    localparam int RW = MNT_W + 2;
    logic [XW-1:0] rexp_q;
    logic [M-1:0]  rmant_q;
    logic          rzero_q, rplus_q, up;
    logic [RW-1:0] rnd;
    assign up    = rmant_q[2] & (rmant_q[1] | rmant_q[0] | rmant_q[3]);
    assign rnd   = {1'b0, rmant_q[M-1:3]} + RW'(up);
    // A rounding carry leaves 1.000..0, so the fraction is zero and the exponent bumps
    assign fexp  = rexp_q + XW'(rnd[RW-1]);
    assign ffrac = rnd[RW-1] ? rnd[MNT_W:1] : rnd[MNT_W-1:0];
    assign fzero = rzero_q;
    assign fplus = rplus_q;
`else
    logic unused_grs;
    assign unused_grs = ^{nmant[M-1], nmant[2:0]};
    assign fexp  = nexp;
    assign ffrac = nmant[M-2:3];
    assign fzero = nzero;
    assign fplus = nplus;
`endif

    logic         fovf;
    logic [W-1:0] fres;
    assign fovf = ~fzero & (fexp >= XW'(2**EXP_W - 1));
    assign fres = fzero ? {sign_q & ~fplus, {(W-1){1'b0}}}
                : fovf  ? {sign_q, {EXP_W{1'b1}}, {MNT_W{1'b0}}}
                :         {sign_q, fexp[EXP_W-1:0], ffrac};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= start_i ? CMP : IDLE;
                    busy_q  <= start_i;
                    if (start_i) begin
                        a_q <= flush(a_i);
                        b_q <= flush({b_i[W-1] ^ op_i, b_i[W-2:0]});
                    end
                end
                CMP: begin
                    state_q <= ALIGN;
                    sign_q  <= gt[W-1];
                    sub_q   <= gt[W-1] ^ lt[W-1];
                    exp_q   <= gt[W-2:MNT_W];
                    edif_q  <= gt[W-2:MNT_W] - lt[W-2:MNT_W];
                    gm_q    <= ext(gt);
                    lm_q    <= ext(lt);
                end
                ALIGN: begin
                    state_q <= ADD;
                    lm_q    <= far ? {{(M-1){1'b0}}, |lm_q}
                             : {lsh[M-1:1], lsh[0] | |(lm_q & ~({M{1'b1}} << edif_q))};
                end
                ADD: begin
                    state_q <= NORM;
                    sum_q   <= sub_q ? {1'b0, gm_q} - {1'b0, lm_q} : {1'b0, gm_q} + {1'b0, lm_q};
                end
`ifdef FPU_ROUND_NEAREST_EN
                NORM: begin
                    state_q <= RND;
                    rexp_q  <= nexp;
                    rmant_q <= nmant;
                    rzero_q <= nzero;
                    rplus_q <= nplus;
                end
                RND: begin
`else
                NORM: begin
`endif
                    state_q  <= DONE;
                    done_q   <= 1'b1;
                    result_q <= fres;
                    ovf_q    <= fovf;
                    zero_q   <= fzero;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = ovf_q;
    assign zero_o     = zero_q;
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: directed vectors for fpu_addsub_seq, FP32, either rounding build.
module tb_fpu_addsub_seq;
`ifdef FPU_ROUND_NEAREST_EN
    localparam int LAT = 6;
    localparam logic [31:0] RND_A = 32'h3F800001;
    localparam logic [31:0] RND_B = 32'h3F800002;
`else
    localparam int LAT = 5;
    localparam logic [31:0] RND_A = 32'h3F800000;
    localparam logic [31:0] RND_B = 32'h3F800001;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, op;
    logic [31:0] a, b, result;
    logic        busy, done, overflow, zero;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fpu_addsub_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .result_o(result), .overflow_o(overflow), .zero_o(zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1 with the inputs scrubbed
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb2, input logic top);
        @(negedge clk);
        a = ta; b = tb2; op = top; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; op = 1'b0;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb2, input logic top,
                       input logic [31:0] er, input logic ez, input logic eo);
        int lat = 1;
        issue(ta, tb2, top);
        check({tag, "/busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "/lat"}, lat, LAT);
        check({tag, "/res"}, result, er);
        check({tag, "/zero"}, 32'(zero), 32'(ez));
        check({tag, "/ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        check({tag, "/pulse"}, 32'(done), 32'd0);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        check({tag, "/hold"}, result, er);
    endtask

    initial begin
        int lat, ndone;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/res", result, 32'h0);
        check("rst/zero", 32'(zero), 32'd0);
        check("rst/ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        run("1+1",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        run("3-1",     32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
        run("1-1",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        run("-1+1",    32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run("max+max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1);
        run("2+-3",    32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 1'b0, 1'b0);
        run("1.5+.25", 32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 1'b0, 1'b0);
        run("denorm",  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        run("uflow",   32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b1, 1'b0);
        run("grs",     32'h3F800000, 32'h33C00000, 1'b0, RND_A,        1'b0, 1'b0);
        run("tie_up",  32'h3F800001, 32'h33800000, 1'b0, RND_B,        1'b0, 1'b0);
        run("tie_dn",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);

        // A start while busy must not disturb the operands already captured
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        @(negedge clk);
        a = 32'h40400000; b = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        wait_done(lat);
        check("ign/lat", lat, LAT);
        check("ign/res", result, 32'h40000000);
        @(negedge clk);
        check("ign/idle", 32'(busy), 32'd0);

        // Back-to-back issue straight out of DONE
        issue(32'h40400000, 32'h3F800000, 1'b0);
        lat = 1;
        wait_done(lat);
        check("b2b/lat1", lat, LAT);
        check("b2b/res1", result, 32'h40800000);
        a = 32'h40400000; b = 32'h3F800000; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; op = 1'b0;
        check("b2b/busy", 32'(busy), 32'd1);
        check("b2b/held", result, 32'h40800000);
        lat = 1;
        wait_done(lat);
        check("b2b/lat2", lat, LAT);
        check("b2b/res2", result, 32'h40000000);

        // Reset in cycle 3 aborts the operation
        issue(32'h40400000, 32'h40400000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/res", result, 32'h0);
        check("abort/done", 32'(done), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort/nodone", ndone, 0);
        check("abort/res2", result, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
